// File: rtl/sort_checker_if.sv
// Sorter result-check interface: the vectors under test, the start/guard handshake
// and the verdict returned by sort_checker.
interface sort_checker_if #(
  parameter int unsigned SIZE  = 16,
  parameter int unsigned WIDTH = 4
);
  localparam int unsigned IDX_W = $clog2(SIZE);

  logic                    start;
  logic                    guard;
  logic [SIZE*WIDTH-1:0]   isrc;
  logic [SIZE*WIDTH-1:0]   itgt;
  logic                    busy;
  logic                    done;
  logic                    pass;
  logic                    err_order;
  logic                    err_perm;
  logic [IDX_W-1:0]        bad_idx;

  // Requester side: presents vectors and start, observes the verdict.
  modport master (
    output start, guard, isrc, itgt,
    input  busy, done, pass, err_order, err_perm, bad_idx
  );

  // Checker side.
  modport slave (
    input  start, guard, isrc, itgt,
    output busy, done, pass, err_order, err_perm, bad_idx
  );
endinterface

// File: rtl/sort_checker.sv
// sort_checker: snapshots an input vector and a Sorter result, then checks the result
// one element per cycle for ordering (SCAN) and, through a signed code histogram,
// for being a permutation of the input (VERIFY). The verdict is held until the next
// accepted start.
module sort_checker #(
  parameter int unsigned SIZE       = 16,
  parameter int unsigned WIDTH      = 4,
  parameter bit          DESCENDING = 1'b0
) (
  input logic           clk,
  input logic           rst_n,
  sort_checker_if.slave bus
);

  localparam int unsigned IDX_W  = $clog2(SIZE);
  localparam int unsigned NBINS  = 2 ** WIDTH;
  // +/-SIZE must be representable without wrapping.
  localparam int unsigned HIST_W = $clog2(SIZE) + 2;

  typedef enum logic [1:0] {StIdle, StScan, StVerify, StDone} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0]         src_q  [SIZE];
  logic [WIDTH-1:0]         src_d  [SIZE];
  logic [WIDTH-1:0]         tgt_q  [SIZE];
  logic [WIDTH-1:0]         tgt_d  [SIZE];
  logic signed [HIST_W-1:0] hist_q [NBINS];
  logic signed [HIST_W-1:0] hist_d [NBINS];

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] vidx_q, vidx_d;
  logic [IDX_W-1:0] bad_idx_q, bad_idx_d;
  logic             err_order_q, err_order_d;
  logic             err_perm_q, err_perm_d;
  logic             pass_q, pass_d;

  logic             accept;
  logic             busy;
  logic [WIDTH-1:0] cur_src;
  logic [WIDTH-1:0] cur_tgt;
  logic [WIDTH-1:0] prev_tgt;
  logic             order_viol;

  assign busy   = (state_q == StScan) || (state_q == StVerify);
  assign accept = bus.start && bus.guard && ((state_q == StIdle) || (state_q == StDone));

  // Elements under inspection this SCAN cycle and the ordering test between neighbours.
  always_comb begin
    cur_src    = src_q[idx_q];
    cur_tgt    = tgt_q[idx_q];
    prev_tgt   = tgt_q[idx_q - 1'b1];
    order_viol = 1'b0;
    if (idx_q != '0) begin
      order_viol = DESCENDING ? (prev_tgt < cur_tgt) : (prev_tgt > cur_tgt);
    end
  end

  // Next-state logic for the FSM, snapshot registers, histogram and verdict.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    tgt_d       = tgt_q;
    hist_d      = hist_q;
    idx_d       = idx_q;
    vidx_d      = vidx_q;
    bad_idx_d   = bad_idx_q;
    err_order_d = err_order_q;
    err_perm_d  = err_perm_q;
    pass_d      = pass_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (state_q == StDone) begin
          state_d = StIdle;
        end
        if (accept) begin
          for (int unsigned i = 0; i < SIZE; i++) begin
            src_d[i] = bus.isrc[i*WIDTH +: WIDTH];
            tgt_d[i] = bus.itgt[i*WIDTH +: WIDTH];
          end
          for (int unsigned b = 0; b < NBINS; b++) begin
            hist_d[b] = '0;
          end
          idx_d       = '0;
          vidx_d      = '0;
          bad_idx_d   = '0;
          err_order_d = 1'b0;
          err_perm_d  = 1'b0;
          pass_d      = 1'b0;
          state_d     = StScan;
        end
      end

      StScan: begin
        // Equal codes cancel, so only touch the histogram when they differ.
        if (cur_src != cur_tgt) begin
          hist_d[cur_src] = hist_q[cur_src] + HIST_W'(1);
          hist_d[cur_tgt] = hist_q[cur_tgt] - HIST_W'(1);
        end
        // Only the first violation records its index.
        if (order_viol && !err_order_q) begin
          err_order_d = 1'b1;
          bad_idx_d   = idx_q;
        end
        if (idx_q == IDX_W'(SIZE - 1)) begin
          vidx_d  = '0;
          state_d = StVerify;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      StVerify: begin
        if (hist_q[vidx_q] != '0) begin
          err_perm_d = 1'b1;
        end
        if (vidx_q == WIDTH'(NBINS - 1)) begin
          pass_d  = !err_order_q && !err_perm_d;
          state_d = StDone;
        end else begin
          vidx_d = vidx_q + 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: snapshots, histogram, counters and held verdict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SIZE; i++) begin
        src_q[i] <= '0;
        tgt_q[i] <= '0;
      end
      for (int unsigned b = 0; b < NBINS; b++) begin
        hist_q[b] <= '0;
      end
      idx_q       <= '0;
      vidx_q      <= '0;
      bad_idx_q   <= '0;
      err_order_q <= 1'b0;
      err_perm_q  <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      src_q       <= src_d;
      tgt_q       <= tgt_d;
      hist_q      <= hist_d;
      idx_q       <= idx_d;
      vidx_q      <= vidx_d;
      bad_idx_q   <= bad_idx_d;
      err_order_q <= err_order_d;
      err_perm_q  <= err_perm_d;
      pass_q      <= pass_d;
    end
  end

  // Verdict outputs read zero while a check is running.
  always_comb begin
    bus.busy      = busy;
    bus.done      = (state_q == StDone);
    bus.pass      = pass_q && !busy;
    bus.err_order = err_order_q && !busy;
    bus.err_perm  = err_perm_q && !busy;
    bus.bad_idx   = busy ? '0 : bad_idx_q;
  end

endmodule

// File: tb/tb_sort_checker.sv
// Directed bench for sort_checker: ascending checker (dut_a) and descending checker (dut_b).
module tb_sort_checker;

  localparam logic [63:0] SRC_PERM = 64'h3A7F0C9215E86BD4;
  localparam logic [63:0] TGT_ASC  = 64'hFEDCBA9876543210;
  localparam logic [63:0] TGT_SWAP = 64'hFEDCBA9875643210;
  localparam logic [63:0] TGT_DUPE = 64'hEEDCBA9876543210;
  localparam logic [63:0] ALL7     = 64'h7777777777777777;
  localparam logic [63:0] TGT_DESC = 64'h0123456789ABCDEF;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   lat;
  int   overlap;

  sort_checker_if #(.SIZE(16), .WIDTH(4)) a_if ();
  sort_checker_if #(.SIZE(16), .WIDTH(4)) b_if ();

  sort_checker #(.SIZE(16), .WIDTH(4), .DESCENDING(1'b0)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a_if)
  );

  sort_checker #(.SIZE(16), .WIDTH(4), .DESCENDING(1'b1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // busy and done must never be high together on either instance.
  always @(negedge clk) begin
    if ((a_if.busy && a_if.done) || (b_if.busy && b_if.done)) overlap++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start a check on dut_a (sel=0) or dut_b (sel=1); lat counts edges with the
  // accept edge as 1 and stops once done is seen (bounded at 100).
  // With disturb set, vectors change and start pulses during SCAN.
  task automatic run(input bit sel, input logic [63:0] s, input logic [63:0] t,
                     input bit disturb, output int n);
    logic d;
    if (sel) begin
      b_if.isrc = s; b_if.itgt = t; b_if.guard = 1'b1; b_if.start = 1'b1;
    end else begin
      a_if.isrc = s; a_if.itgt = t; a_if.guard = 1'b1; a_if.start = 1'b1;
    end
    @(posedge clk);
    #1;
    a_if.start = 1'b0;
    b_if.start = 1'b0;
    n = 1;
    d = 1'b0;
    while (!d && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (disturb && n == 5) begin
        a_if.isrc = ALL7; a_if.itgt = TGT_SWAP; a_if.start = 1'b1;
      end else if (disturb && n == 6) begin
        a_if.start = 1'b0;
      end
      d = sel ? b_if.done : a_if.done;
    end
  endtask

  task automatic verdict(input bit sel, input string tag, input logic p, input logic eo,
                         input logic ep, input logic [3:0] bi);
    if (sel) begin
      chk({tag, " pass"}, 32'(b_if.pass), 32'(p));
      chk({tag, " err_order"}, 32'(b_if.err_order), 32'(eo));
      chk({tag, " err_perm"}, 32'(b_if.err_perm), 32'(ep));
      chk({tag, " bad_idx"}, 32'(b_if.bad_idx), 32'(bi));
    end else begin
      chk({tag, " pass"}, 32'(a_if.pass), 32'(p));
      chk({tag, " err_order"}, 32'(a_if.err_order), 32'(eo));
      chk({tag, " err_perm"}, 32'(a_if.err_perm), 32'(ep));
      chk({tag, " bad_idx"}, 32'(a_if.bad_idx), 32'(bi));
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    overlap = 0;
    rst_n   = 1'b0;
    a_if.start = 1'b0; a_if.guard = 1'b0; a_if.isrc = '0; a_if.itgt = '0;
    b_if.start = 1'b0; b_if.guard = 1'b0; b_if.isrc = '0; b_if.itgt = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 32'(a_if.busy), 32'd0);
    chk("reset done", 32'(a_if.done), 32'd0);
    verdict(1'b0, "reset", 1'b0, 1'b0, 1'b0, 4'd0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: permuted source, ascending result.
    run(1'b0, SRC_PERM, TGT_ASC, 1'b0, lat);
    chk("t1 latency", 32'(lat), 32'd33);
    chk("t1 busy in done", 32'(a_if.busy), 32'd0);
    verdict(1'b0, "t1", 1'b1, 1'b0, 1'b0, 4'd0);
    @(posedge clk);
    #1;
    chk("t1 done one cycle", 32'(a_if.done), 32'd0);
    chk("t1 pass held", 32'(a_if.pass), 32'd1);

    // 2: elements 5 and 6 swapped.
    run(1'b0, TGT_ASC, TGT_SWAP, 1'b0, lat);
    chk("t2 latency", 32'(lat), 32'd33);
    verdict(1'b0, "t2", 1'b0, 1'b1, 1'b0, 4'd6);

    // 3: last element duplicated instead of 0xF.
    run(1'b0, SRC_PERM, TGT_DUPE, 1'b0, lat);
    verdict(1'b0, "t3", 1'b0, 1'b0, 1'b1, 4'd0);

    // 4: all-equal vectors; descending instance on descending and ascending results.
    run(1'b0, ALL7, ALL7, 1'b0, lat);
    verdict(1'b0, "t4 equal", 1'b1, 1'b0, 1'b0, 4'd0);
    run(1'b1, SRC_PERM, TGT_DESC, 1'b0, lat);
    chk("t4 desc latency", 32'(lat), 32'd33);
    verdict(1'b1, "t4 desc", 1'b1, 1'b0, 1'b0, 4'd0);
    run(1'b1, SRC_PERM, TGT_ASC, 1'b0, lat);
    verdict(1'b1, "t4 desc on asc", 1'b0, 1'b1, 1'b0, 4'd1);

    // 5a: start with guard low is ignored; previous verdict stays held.
    repeat (2) @(posedge clk);
    #1;
    a_if.isrc = SRC_PERM; a_if.itgt = TGT_SWAP; a_if.guard = 1'b0; a_if.start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t5 guard busy", 32'(a_if.busy), 32'd0);
    chk("t5 guard held pass", 32'(a_if.pass), 32'd1);
    a_if.start = 1'b0;

    // 5b: start and input changes during SCAN ignored; then back-to-back start in DONE.
    run(1'b0, SRC_PERM, TGT_ASC, 1'b1, lat);
    chk("t5 disturb latency", 32'(lat), 32'd33);
    verdict(1'b0, "t5 disturb", 1'b1, 1'b0, 1'b0, 4'd0);
    run(1'b0, TGT_ASC, TGT_SWAP, 1'b0, lat);
    chk("t5 b2b latency", 32'(lat), 32'd33);
    verdict(1'b0, "t5 b2b", 1'b0, 1'b1, 1'b0, 4'd6);

    // 6: asynchronous reset in cycle 10 of a check.
    a_if.isrc = SRC_PERM; a_if.itgt = TGT_DUPE; a_if.guard = 1'b1; a_if.start = 1'b1;
    @(posedge clk);
    #1;
    a_if.start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    chk("t6 busy before reset", 32'(a_if.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6 reset busy", 32'(a_if.busy), 32'd0);
    chk("t6 reset done", 32'(a_if.done), 32'd0);
    verdict(1'b0, "t6 reset", 1'b0, 1'b0, 1'b0, 4'd0);
    @(posedge clk);
    #1;
    chk("t6 held in reset", 32'(a_if.busy), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    run(1'b0, SRC_PERM, TGT_ASC, 1'b0, lat);
    chk("t6 fresh latency", 32'(lat), 32'd33);
    verdict(1'b0, "t6 fresh", 1'b1, 1'b0, 1'b0, 4'd0);

    chk("busy and done overlap", 32'(overlap), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
